ring_counter_param: RTL and testbench

Parametrised successor to the fixed 8-bit rotate-left ring counter. It provides:
- configurable width and seed;
- rotate-left, rotate-right, Johnson (twisted-ring) and hold modes;
- clock enable and synchronous parallel load;
- a step counter and a registered wrap pulse, one per full period.

It is used as a sequence/phase generator for LED chasers and display scan strobes in lab top-levels.

---
 rtl/ring_pkg.sv | 14 +
 rtl/ring_step_counter.sv | 46 ++++
 rtl/ring_counter_param.sv | 69 ++++++
 tb/tb_ring_counter_param.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared mode encodings and period helper for the ring counter
package ring_pkg;

  localparam logic [1:0] MODE_ROT_L     = 2'b00;
  localparam logic [1:0] MODE_ROT_R     = 2'b01;
  localparam logic [1:0] MODE_JOHNSON_L = 2'b10;
  localparam logic [1:0] MODE_HOLD      = 2'b11;

  // Johnson rings take twice as many advances to return to the start pattern.
  function automatic int unsigned period_of(input logic [1:0] mode, input int unsigned width);
    return (mode == MODE_JOHNSON_L) ? 2 * width : width;
  endfunction

endpackage

// File: rtl/ring_step_counter.sv
// rtl/ring_step_counter.sv - modulo-period advance counter with registered wrap strobe
module ring_step_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic          clr,
  input  logic [CW:0]   period,
  output logic [CW-1:0] step,
  output logic          wrap
);

  logic [CW-1:0] step_q, step_d;
  logic          wrap_q, wrap_d;

  // A clear that coincides with an advance counts that advance as the first step.
  always_comb begin
    step_d = step_q;
    wrap_d = 1'b0;
    if (clr) begin
      step_d = adv ? CW'(1) : '0;
    end else if (adv) begin
      if ({1'b0, step_q} == period - (CW+1)'(1)) begin
        step_d = '0;
        wrap_d = 1'b1;
      end else begin
        step_d = step_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  assign step = step_q;
  assign wrap = wrap_q;

endmodule

// File: rtl/ring_counter_param.sv
// rtl/ring_counter_param.sv - parametrised rotate/Johnson ring counter with step and wrap outputs
module ring_counter_param
  import ring_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = WIDTH'(8'b01010101)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         load,
  input  logic [WIDTH-1:0]             seed,
  input  logic [1:0]                   mode,
  output logic [WIDTH-1:0]             q,
  output logic [$clog2(2*WIDTH)-1:0]   step,
  output logic                         wrap
);

  localparam int CW = $clog2(2 * WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  logic [1:0]       mode_q, mode_d;
  logic             adv;
  logic             mode_change;
  logic [CW:0]      period;

  assign adv         = en & (mode != MODE_HOLD);
  assign mode_change = (mode != mode_q);
  assign period      = (CW+1)'(period_of(mode, WIDTH));

  always_comb begin
    q_d    = q_q;
    mode_d = mode;
    if (load) begin
      q_d = seed;
    end else if (adv) begin
      case (mode)
        MODE_ROT_L:     q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        MODE_ROT_R:     q_d = {q_q[0], q_q[WIDTH-1:1]};
        MODE_JOHNSON_L: q_d = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
        default:        q_d = q_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= INIT;
      mode_q <= MODE_ROT_L;
    end else begin
      q_q    <= q_d;
      mode_q <= mode_d;
    end
  end

  // Load restarts the count without advancing; a mode change restarts it but may advance.
  ring_step_counter #(.CW(CW)) u_step (
    .clk    (clk),
    .rst    (rst),
    .adv    (adv & ~load),
    .clr    (load | mode_change),
    .period (period),
    .step   (step),
    .wrap   (wrap)
  );

  assign q = q_q;

endmodule

// File: tb/tb_ring_counter_param.sv
// tb/tb_ring_counter_param.sv - randomized and directed self-checking bench for ring_counter_param
module tb_ring_counter_param;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [7:0] seed;
  logic [1:0] mode;
  logic [7:0] q;
  logic [3:0] step;
  logic       wrap;

  int n_tests = 0;
  int n_fail  = 0;

  int m_q, m_step, m_mode;
  bit m_wrap;

  ring_counter_param #(.WIDTH(8), .INIT(8'h55)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .load (load),
    .seed (seed),
    .mode (mode),
    .q    (q),
    .step (step),
    .wrap (wrap)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int shift_of(input int v, input int m);
    case (m)
      0:       return (v * 2) % 256 + v / 128;
      1:       return v / 2 + (v % 2) * 128;
      2:       return (v * 2) % 256 + (1 - v / 128);
      default: return v;
    endcase
  endfunction

  // Reference: step is a count of advances modulo the period of the current mode.
  task automatic model_edge(input bit r, input bit l, input bit e, input int s, input int m);
    bit a;
    int per;
    if (r) begin
      m_q = 8'h55; m_step = 0; m_wrap = 0; m_mode = 0;
    end else if (l) begin
      m_q = s; m_step = 0; m_wrap = 0; m_mode = m;
    end else begin
      a   = e && (m != 3);
      per = (m == 2) ? 16 : 8;
      if (m != m_mode) begin
        m_step = a ? 1 : 0;
        m_wrap = 0;
      end else if (a) begin
        m_step = (m_step + 1) % per;
        m_wrap = (m_step == 0);
      end else begin
        m_wrap = 0;
      end
      if (a) m_q = shift_of(m_q, m);
      m_mode = m;
    end
  endtask

  task automatic cyc(input bit r, input bit l, input bit e, input logic [7:0] s, input logic [1:0] m);
    rst = r; load = l; en = e; seed = s; mode = m;
    @(posedge clk);
    model_edge(r, l, e, int'(s), int'(m));
    #1;
    check_eq("q", 32'(q), 32'(m_q));
    check_eq("step", 32'(step), 32'(m_step));
    check_eq("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  logic [3:0] step_hold;
  logic [1:0] rmode;

  initial begin
    rst = 1'b1; load = 1'b0; en = 1'b0; seed = 8'h00; mode = 2'b00;

    cyc(1, 0, 0, 8'h00, 2'b00);
    cyc(1, 0, 0, 8'h00, 2'b00);
    check_eq("t1_reset_q", 32'(q), 32'h55);
    cyc(0, 0, 1, 8'h00, 2'b00);
    check_eq("t1_edge1_q", 32'(q), 32'hAA);
    check_eq("t1_edge1_step", 32'(step), 32'd1);
    cyc(0, 0, 1, 8'h00, 2'b00);
    check_eq("t1_edge2_q", 32'(q), 32'h55);
    for (int i = 3; i <= 8; i++) cyc(0, 0, 1, 8'h00, 2'b00);
    check_eq("t1_wrap", 32'(wrap), 32'd1);
    check_eq("t1_wrap_step", 32'(step), 32'd0);

    cyc(0, 1, 1, 8'h01, 2'b01);
    cyc(0, 0, 1, 8'h00, 2'b01);
    check_eq("t2_first_q", 32'(q), 32'h80);
    for (int i = 2; i <= 8; i++) cyc(0, 0, 1, 8'h00, 2'b01);
    check_eq("t2_eighth_q", 32'(q), 32'h01);
    check_eq("t2_wrap", 32'(wrap), 32'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 8'h00, 2'b01);
    check_eq("t2_frozen_q", 32'(q), 32'h01);
    check_eq("t2_frozen_wrap", 32'(wrap), 32'd0);

    cyc(0, 1, 1, 8'h00, 2'b10);
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 0, 1, 8'h00, 2'b10);
      if (i == 8) begin
        check_eq("t3_q8", 32'(q), 32'hFF);
        check_eq("t3_nowrap8", 32'(wrap), 32'd0);
      end
      if (i == 9) check_eq("t3_q9", 32'(q), 32'hFE);
    end
    check_eq("t3_q16", 32'(q), 32'h00);
    check_eq("t3_wrap16", 32'(wrap), 32'd1);

    cyc(0, 1, 1, 8'h3C, 2'b10);
    check_eq("t4_load_q", 32'(q), 32'h3C);
    check_eq("t4_load_step", 32'(step), 32'd0);

    cyc(0, 1, 0, 8'h01, 2'b00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'h00, 2'b00);
    check_eq("t5_pre_step", 32'(step), 32'd5);
    cyc(0, 0, 1, 8'h00, 2'b01);
    check_eq("t5_rotr_q", 32'(q), 32'h10);
    check_eq("t5_rotr_step", 32'(step), 32'd1);
    cyc(0, 0, 1, 8'h00, 2'b11);
    step_hold = step;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h00, 2'b11);
    check_eq("t5_hold_q", 32'(q), 32'h10);
    check_eq("t5_hold_step", 32'(step), 32'(step_hold));

    cyc(0, 1, 0, 8'h00, 2'b10);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 8'h00, 2'b10);
    check_eq("t6_pre_step", 32'(step), 32'd5);
    cyc(1, 1, 1, 8'hFF, 2'b10);
    check_eq("t6_rst_q", 32'(q), 32'h55);
    check_eq("t6_rst_step", 32'(step), 32'd0);

    rmode = 2'b00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) rmode = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3) != 0, 8'($urandom), rmode);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
